cache_mem_ctrl: RTL and testbench
=================================

// Module: cache_mem_ctrl
// PURPOSE
//  Memory-side responder for the write-back data cache. Accepts dirty-line evictions into a
//  write buffer, drains them to a single-port backing memory, and serves cache refill reads
//  with fixed latency. Sits between the cache (dirty/refill interface) and data memory.
// PARAMETERS
//  ADDR_WIDTH    32  byte address width; word address = addr[ADDR_WIDTH-1:2]
//  DATA_WIDTH    32  data word width
//  WB_DEPTH      4   write-buffer entries (power of 2, >=2)
//  READ_LATENCY  3   cycles from request acceptance to resp_valid (>=2)
// PORTS
//  clk        in   1           clock
//  reset      in   1           synchronous, active-high reset
//  req_valid  in   1           cache refill request
//  req_addr   in   ADDR_WIDTH  refill byte address (bits [1:0] ignored)
//  req_ready  out  1           request accepted on edge when req_valid && req_ready
//  resp_valid out  1           one-cycle pulse: resp_data holds refill word
//  resp_data  out  DATA_WIDTH  refill data (registered)
//  wb_en      in   1           eviction push (cache dirty_en)
//  wb_addr    in   ADDR_WIDTH  evicted line address (cache dirty_add)
//  wb_data    in   DATA_WIDTH  evicted data (cache dirty_data)
//  wb_ready   out  1           = !full; push occurs on edge when wb_en && wb_ready
//  wb_empty   out  1           write buffer empty
//  mem_re     out  1           backing-memory read strobe
//  mem_we     out  1           backing-memory write strobe
//  mem_addr   out  ADDR_WIDTH  backing-memory byte address, word aligned
//  mem_wdata  out  DATA_WIDTH  write data
//  mem_rdata  in   DATA_WIDTH  read data, valid the cycle after mem_re (1-cycle sync read)
// BEHAVIOUR
//  - Reset: state IDLE, FIFO emptied (pending writebacks discarded, also mid-read); resp_valid=0,
//    resp_data=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0; wb_ready=1, wb_empty=1, req_ready=1.
//  - FSM: IDLE -> WAIT on accept (cycle T); WAIT counts; RESP in cycle T+READ_LATENCY -> IDLE.
//    WAIT: mem_re=1, mem_addr=req word addr in cycle T+1 only; mem_rdata captured into resp_data
//    at end of T+2; hold until RESP. RESP: resp_valid=1 exactly one cycle; req_ready=0.
//    Back-to-back requests: next accept earliest in cycle after RESP.
//  - req_ready = (state==IDLE) && !hazard. hazard = req word addr equals any valid FIFO entry
//    OR the same-cycle incoming push (wb_en && wb_ready).
//  - Write buffer: circular FIFO, WB_DEPTH entries, ptrs wrap mod WB_DEPTH, count 0..WB_DEPTH.
//    Pushes accepted in any state. Full: wb_ready=0, push ignored (no push-through on pop).
//  - Drain: in IDLE, FIFO non-empty, and no request accepted this cycle -> mem_we=1,
//    mem_addr/mem_wdata = head entry, pop on edge. Reads take priority; no drain in WAIT/RESP.
//    Simultaneous push+pop: count unchanged. mem_re and mem_we never both high.
//  - Entries drained in push order; duplicate addresses allowed, youngest wins in memory.
// CONFIGURATION
//  WB_FORWARD_EN defined: hazard forced 0; a matching request is accepted, no mem_re issued,
//    resp_data = youngest matching entry (incoming push beats FIFO), same READ_LATENCY.
//  WB_FORWARD_EN undefined: matching request stalls (req_ready=0); drain continues until the
//    matching entries leave, then accepted and read from memory normally.
// TESTING
//  1 Reset, mem[0x40]=0xDEADBEEF, req 0x40 at T -> mem_re at T+1, resp_valid=1 only at T+3, data 0xDEADBEEF.
//  2 Push 4 entries 0x100..0x10C (data 1..4), no reqs -> wb_ready=0 after 4th; 4 mem_we cycles in order;
//    wb_empty=1 after; 5th push while full dropped.
//  3 Push {0x200,0xCAFE} then req 0x200 same cycle -> no fwd: req_ready=0, mem_we 0x200, then read
//    returns 0xCAFE; fwd: accepted, no mem_re, resp 0xCAFE at T+3.
//  4 FIFO holds 2 entries, req 0x300 valid in IDLE -> read wins, no mem_we until after RESP, then drain.
//  5 Push two entries to 0x80 (0x11 then 0x22) -> memory ends 0x22; fwd build returns 0x22 for req 0x80.
//  6 reset asserted in WAIT with 3 buffered entries -> next cycle IDLE, resp_valid never pulses,
//    wb_empty=1, no mem_we issued.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder for the write-back data cache: buffers dirty-line evictions, drains them
// to a single-port memory and serves fixed-latency refill reads. Define WB_FORWARD_EN to forward.
module cache_mem_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int WB_DEPTH     = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  input  logic                  wb_en_i,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  wb_ready_o,
  output logic                  wb_empty_o,
  output logic                  mem_re_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam int WA_W  = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [WA_W-1:0]       req_waddr_q;
  logic                  fwd_q;
  logic                  re_pend_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [WB_DEPTH-1:0]   wb_valid_q;
  logic [WA_W-1:0]       wb_waddr_mem [WB_DEPTH];
  logic [DATA_WIDTH-1:0] wb_data_mem  [WB_DEPTH];

  logic [WA_W-1:0] req_waddr, push_waddr;
  logic            push, pop, accept, rd_strobe;
  logic            hazard, fifo_hit, push_hit, fwd_hit;
  logic            unused_addr_bits;

  assign req_waddr        = req_addr_i[ADDR_WIDTH-1:2];
  assign push_waddr       = wb_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{req_addr_i[1:0], wb_addr_i[1:0]};

  assign wb_ready_o = (count_q != CNT_W'(WB_DEPTH));
  assign wb_empty_o = (count_q == '0);
  assign push       = wb_en_i && wb_ready_o && !reset;
  assign push_hit   = push && (push_waddr == req_waddr);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (wb_valid_q[i] && (wb_waddr_mem[i] == req_waddr)) fifo_hit = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [PTR_W-1:0]      age_idx;

  // Walk oldest to youngest so the last match wins; a same-cycle push is younger still.
  always_comb begin
    fwd_data = '0;
    age_idx  = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      age_idx = rd_ptr_q + PTR_W'(k);
      if (wb_valid_q[age_idx] && (wb_waddr_mem[age_idx] == req_waddr)) begin
        fwd_data = wb_data_mem[age_idx];
      end
    end
    if (push_hit) fwd_data = wb_data_i;
  end

  assign hazard  = 1'b0;
  assign fwd_hit = fifo_hit || push_hit;
`else
  assign hazard  = fifo_hit || push_hit;
  assign fwd_hit = 1'b0;
`endif

  assign req_ready_o = (state_q == ST_IDLE) && !hazard;
  assign accept      = req_valid_i && req_ready_o && !reset;
  assign pop         = (state_q == ST_IDLE) && !wb_empty_o && !accept && !reset;
  assign rd_strobe   = (state_q == ST_WAIT) && (lat_q == LAT_W'(1)) && !fwd_q && !reset;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY - 1)) state_d = ST_RESP;
        else                                   lat_d   = lat_q + LAT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rd_strobe) begin
      mem_addr_o = {req_waddr_q, 2'b00};
    end else if (pop) begin
      mem_addr_o  = {wb_waddr_mem[rd_ptr_q], 2'b00};
      mem_wdata_o = wb_data_mem[rd_ptr_q];
    end
  end

  assign mem_re_o     = rd_strobe;
  assign mem_we_o     = pop;
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_data_o  = resp_data_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lat_q       <= '0;
      req_waddr_q <= '0;
      fwd_q       <= 1'b0;
      re_pend_q   <= 1'b0;
      resp_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wb_valid_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      re_pend_q <= rd_strobe;
      if (accept) begin
        req_waddr_q <= req_waddr;
        fwd_q       <= fwd_hit;
      end
      if (re_pend_q) resp_data_q <= mem_rdata_i;
`ifdef WB_FORWARD_EN
      if (accept && fwd_hit) resp_data_q <= fwd_data;
`endif
      if (push) begin
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
        wb_valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q             <= rd_ptr_q + PTR_W'(1);
        wb_valid_q[rd_ptr_q] <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: buffer storage has no reset; wb_valid_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      wb_waddr_mem[wr_ptr_q] <= push_waddr;
      wb_data_mem[wr_ptr_q]  <= wb_data_i;
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Scoreboard bench for cache_mem_ctrl: directed refills and evictions against a 1-cycle memory.
// Expected mem_re, mem_we and resp events are queued at issue time and popped by a monitor.
module tb_cache_mem_ctrl;

  localparam int RL = 3;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, resp_valid;
  logic [31:0] req_addr, resp_data;
  logic        wb_en, wb_ready, wb_empty;
  logic [31:0] wb_addr, wb_data;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_mem_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_DEPTH(4), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .wb_ready_o(wb_ready), .wb_empty_o(wb_empty),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory: word w preloads to {A500, byte address}, except word 0x10 (0x40).
  function automatic logic [31:0] mem_default(input int w);
    if (w == 'h10) return 32'hDEADBEEF;
    return {16'hA500, 16'(w << 2)};
  endfunction

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 1024; i++) mem[i] <= mem_default(i);
    end else begin
      if (mem_re) mem_rdata <= mem[mem_addr[11:2]];
      if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  typedef struct { logic [31:0] addr; int cyc; } re_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } we_t;
  typedef struct { logic [31:0] data; int cyc; } resp_t;

  re_t   exp_re[$];
  we_t   exp_we[$];
  resp_t exp_resp[$];
  int    we_cycles[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  re_t   mr;
  we_t   mw;
  resp_t mp;
  always @(negedge clk) begin
    if (mem_re || mem_we) check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
    if (mem_re) begin
      check("mem_re_expected", 32'(exp_re.size() != 0), 32'd1);
      if (exp_re.size() != 0) begin
        mr = exp_re.pop_front();
        check("mem_re_addr", mem_addr, mr.addr);
        check("mem_re_cycle", cyc, mr.cyc);
      end
    end
    if (mem_we) begin
      we_cycles.push_back(cyc);
      check("mem_we_expected", 32'(exp_we.size() != 0), 32'd1);
      if (exp_we.size() != 0) begin
        mw = exp_we.pop_front();
        check("mem_we_addr", mem_addr, mw.addr);
        check("mem_we_data", mem_wdata, mw.data);
      end
    end
    if (resp_valid) begin
      check("resp_expected", 32'(exp_resp.size() != 0), 32'd1);
      if (exp_resp.size() != 0) begin
        mp = exp_resp.pop_front();
        check("resp_data", resp_data, mp.data);
        check("resp_cycle", cyc, mp.cyc);
      end
    end
  end

  // All driver tasks start and end one time unit after a rising edge.
  task automatic do_req(input logic [31:0] addr, input bit exp_re_en, input logic [31:0] re_addr,
                        input bit exp_resp_en, input logic [31:0] data, output int t);
    t = -1;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready) begin
        t = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check("req_accepted", 32'(t >= 0), 32'd1);
    if (t >= 0 && exp_re_en)   exp_re.push_back('{addr: re_addr, cyc: t + 1});
    if (t >= 0 && exp_resp_en) exp_resp.push_back('{data: data, cyc: t + RL});
    @(posedge clk); #1;
  endtask

  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input bit exp_drain,
                         output bit acc);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    #1;
    acc = wb_ready;
    if (acc && exp_drain) exp_we.push_back('{addr: a, data: d});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    bit done = 1'b0;
    idle(4);
    for (int n = 0; n < 40; n++) begin
      if (wb_empty) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("wb_drained", 32'(done), 32'd1);
    idle(1);
  endtask

  function automatic int we_at(input int i);
    return (we_cycles.size() > i) ? we_cycles[i] : -1;
  endfunction

  int c, t1, t2;
  bit acc_a, acc_b;

  initial begin
    #100000;
    $display("FAIL watchdog: stuck at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_re", 32'(mem_re), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_wb_empty", 32'(wb_empty), 32'd1);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    idle(1);

    // 1: plain refill, mem_re at T+1, pulse at T+3.
    do_req(32'h40, 1'b1, 32'h40, 1'b1, 32'hDEADBEEF, t1);
    req_valid = 1'b0;
    settle();

    // 2: fill the buffer behind a read (unaligned req address), 5th push dropped, in-order drain.
    c = cyc;
    we_cycles.delete();
    fork
      begin
        do_req(32'h7F2, 1'b1, 32'h7F0, 1'b1, 32'hA50007F0, t1);
        req_valid = 1'b0;
      end
      begin
        do_push(32'h100, 32'd1, 1'b1, acc_a);
        do_push(32'h104, 32'd2, 1'b1, acc_a);
        do_push(32'h108, 32'd3, 1'b1, acc_a);
        do_push(32'h10C, 32'd4, 1'b1, acc_a);
        do_push(32'h110, 32'd5, 1'b1, acc_b);
        wb_en = 1'b0;
      end
    join
    check("t2_accept_cycle", t1, c);
    check("t2_full_push_dropped", 32'(acc_b), 32'd0);
    settle();
    check("t2_we_count", we_cycles.size(), 32'd4);
    check("t2_we0_cycle", we_at(0), c + 4);
    check("t2_we3_cycle", we_at(3), c + 7);
    check("t2_empty_after", 32'(wb_empty), 32'd1);

    // 3: request hits a same-cycle push of the same word.
    c = cyc;
    we_cycles.delete();
    fork
      do_req(32'h200, !FWD, 32'h200, 1'b1, 32'h0000CAFE, t1);
      begin
        do_push(32'h200, 32'h0000CAFE, 1'b1, acc_a);
        wb_en = 1'b0;
      end
    join
    req_valid = 1'b0;
    check("t3_accept_cycle", t1, FWD ? c : c + 2);
    settle();
    check("t3_first_we_cycle", we_at(0), FWD ? c + 4 : c + 1);

    // 4: buffered entries wait while back-to-back reads are served.
    c = cyc;
    we_cycles.delete();
    fork
      begin
        do_req(32'h500, 1'b1, 32'h500, 1'b1, 32'hA5000500, t1);
        do_req(32'h300, 1'b1, 32'h300, 1'b1, 32'hA5000300, t2);
        req_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        do_push(32'h600, 32'h66, 1'b1, acc_a);
        do_push(32'h604, 32'h77, 1'b1, acc_a);
        wb_en = 1'b0;
      end
    join
    check("t4_first_accept", t1, c);
    check("t4_second_accept", t2, c + 4);
    settle();
    check("t4_we_count", we_cycles.size(), 32'd2);
    check("t4_we0_cycle", we_at(0), c + 8);
    check("t4_we1_cycle", we_at(1), c + 9);

    // 5: duplicate evictions to 0x80, youngest must win.
    c = cyc;
    fork
      begin
        do_req(32'h7A0, 1'b1, 32'h7A0, 1'b1, 32'hA50007A0, t1);
        do_req(32'h80, !FWD, 32'h80, 1'b1, 32'h22, t2);
        req_valid = 1'b0;
      end
      begin
        @(posedge clk); #1;
        do_push(32'h80, 32'h11, 1'b1, acc_a);
        do_push(32'h80, 32'h22, 1'b1, acc_a);
        wb_en = 1'b0;
      end
    join
    check("t5_req80_accept", t2, FWD ? c + 4 : c + 6);
    settle();
    check("t5_mem80_final", mem[32], 32'h22);

    // 6: reset during WAIT with three buffered entries.
    c = cyc;
    we_cycles.delete();
    fork
      begin
        do_req(32'h880, 1'b1, 32'h880, 1'b1, 32'hA5000880, t1);
        do_req(32'h900, 1'b0, 32'h0, 1'b0, 32'h0, t2);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
      end
      begin
        @(posedge clk); #1;
        do_push(32'hA00, 32'h1, 1'b0, acc_a);
        do_push(32'hA04, 32'h2, 1'b0, acc_a);
        do_push(32'hA08, 32'h3, 1'b0, acc_a);
        wb_en = 1'b0;
      end
    join
    #1;
    check("t6_b_accept", t2, c + 4);
    check("t6_wb_empty", 32'(wb_empty), 32'd1);
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_resp_valid", 32'(resp_valid), 32'd0);
    check("t6_resp_data", resp_data, 32'd0);
    idle(8);
    check("t6_no_mem_we", we_cycles.size(), 32'd0);

    check("left_exp_re", exp_re.size(), 32'd0);
    check("left_exp_we", exp_we.size(), 32'd0);
    check("left_exp_resp", exp_resp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
